// File: rtl/shift_ram_pkg.sv
// rtl/shift_ram_pkg.sv - shared constants and length helpers for the multi-channel shift RAM delay
package shift_ram_pkg;

    localparam int MIN_DEPTH = 1;

    function automatic int clog2_c(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int clamp_len(input int len, input int max_depth);
        if (len < MIN_DEPTH) begin
            return MIN_DEPTH;
        end
        if (len > max_depth) begin
            return max_depth;
        end
        return len;
    endfunction

    function automatic bit depth_in_range(input int len, input int max_depth);
        return (len >= MIN_DEPTH) && (len <= max_depth);
    endfunction

endpackage

// File: rtl/shift_ram_bank.sv
// rtl/shift_ram_bank.sv - one lane of storage: simple dual-port RAM with same-address read-before-write
module shift_ram_bank #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] mem [DEPTH];

    // RAM array carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/shift_ram_delay_mc.sv
// rtl/shift_ram_delay_mc.sv - multi-lane RAM delay line with runtime length, valid tracking and flush on load
module shift_ram_delay_mc
    import shift_ram_pkg::*;
#(
    parameter int CH            = 4,
    parameter int WIDTH         = 64,
    parameter int MAX_DEPTH     = 256,
    parameter int DEFAULT_DEPTH = 256,
    parameter int LW            = clog2_c(MAX_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                in_valid,
    input  logic [CH*WIDTH-1:0] d,
    input  logic [LW-1:0]       dly_len,
    input  logic                dly_load,
    output logic [CH*WIDTH-1:0] q,
    output logic                q_valid,
    output logic [LW-1:0]       cur_len,
    output logic                cfg_clamped
);

    localparam int AW        = (clog2_c(MAX_DEPTH) > 0) ? clog2_c(MAX_DEPTH) : 1;
    localparam int RESET_LEN = depth_in_range(DEFAULT_DEPTH, MAX_DEPTH) ?
                               DEFAULT_DEPTH : clamp_len(DEFAULT_DEPTH, MAX_DEPTH);

    logic [AW-1:0]        ptr;
    logic [MAX_DEPTH-1:0] vbit;
    logic                 advance;
    logic                 last_slot;
    logic                 clamped;
    logic [LW-1:0]        next_len;
    int                   load_len;

    // A load takes priority over a same-cycle sample, so the RAM never sees that sample.
    assign advance   = ce & ~dly_load;
    assign last_slot = (LW'(ptr) == (cur_len - LW'(1)));

    always_comb begin
        load_len = clamp_len(int'(dly_len), MAX_DEPTH);
        next_len = LW'(load_len);
        clamped  = (load_len != int'(dly_len));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            cur_len     <= LW'(RESET_LEN);
            vbit        <= '0;
            q_valid     <= 1'b0;
            cfg_clamped <= 1'b0;
        end else begin
            cfg_clamped <= 1'b0;
            if (dly_load) begin
                // Clearing vbit flushes every stale entry without touching the RAM.
                cur_len     <= next_len;
                ptr         <= '0;
                vbit        <= '0;
                q_valid     <= 1'b0;
                cfg_clamped <= clamped;
            end else if (ce) begin
                q_valid   <= vbit[ptr];
                vbit[ptr] <= in_valid;
                ptr       <= last_slot ? '0 : ptr + AW'(1);
            end
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_lane
        shift_ram_bank #(
            .WIDTH (WIDTH),
            .DEPTH (MAX_DEPTH),
            .AW    (AW)
        ) u_bank (
            .clk  (clk),
            .rst  (rst),
            .en   (advance),
            .addr (ptr),
            .d    (d[k*WIDTH +: WIDTH]),
            .q    (q[k*WIDTH +: WIDTH])
        );
    end

endmodule
